// File: rtl/int_sync_pkg.sv
// Shared constants, channel-mode type and helpers for the multi-channel interrupt crossing sink.
package int_sync_pkg;

  localparam int INT_SYNC_DEFAULT_DEPTH = 3;
  localparam int INT_SYNC_MIN_DEPTH     = 2;

  typedef enum logic {
    INT_LEVEL = 1'b0,
    INT_EDGE  = 1'b1
  } int_mode_e;

  // Glitch-filter counter only has to reach FILTER_LEN-1; sized for FILTER_LEN+1 values.
  function automatic int filter_cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  function automatic int_mode_e chan_mode(input logic edge_bit);
    return edge_bit ? INT_EDGE : INT_LEVEL;
  endfunction

endpackage

// File: rtl/sync_chain_reg.sv
// Single-bit asynchronous-reset synchronizer chain of SYNC_DEPTH flops; q is the last stage.
module sync_chain_reg
  import int_sync_pkg::*;
#(
  parameter int SYNC_DEPTH = INT_SYNC_DEFAULT_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_DEPTH < INT_SYNC_MIN_DEPTH) begin : g_bad_depth
    $error("sync_chain_reg: SYNC_DEPTH must be at least %0d", INT_SYNC_MIN_DEPTH);
  end

  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/int_sync_crossing_sink_multi.sv
// Multi-channel interrupt crossing sink: per-channel synchronizer, optional glitch filter
// (INT_SYNC_FILTER_EN), then level passthrough or sticky rising-edge pending bit with clear.
module int_sync_crossing_sink_multi
  import int_sync_pkg::*;
#(
  parameter int                 NUM_INT    = 4,
  parameter int                 SYNC_DEPTH = INT_SYNC_DEFAULT_DEPTH,
  parameter logic [NUM_INT-1:0] EDGE_MASK  = '0,
  parameter int                 FILTER_LEN = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] in_sync,
  input  logic [NUM_INT-1:0] clear,
  output logic [NUM_INT-1:0] out,
  output logic               any
);

  if (NUM_INT < 1) begin : g_bad_num
    $error("int_sync_crossing_sink_multi: NUM_INT must be at least 1");
  end
  if (SYNC_DEPTH < INT_SYNC_MIN_DEPTH) begin : g_bad_depth
    $error("int_sync_crossing_sink_multi: SYNC_DEPTH must be at least %0d", INT_SYNC_MIN_DEPTH);
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("int_sync_crossing_sink_multi: FILTER_LEN must be at least 1");
  end

  logic [NUM_INT-1:0] s;     // synchronized lines
  logic [NUM_INT-1:0] f;     // filtered lines (equal to s without the filter)
  logic [NUM_INT-1:0] h;     // one-cycle history of f for rise detection
  logic [NUM_INT-1:0] pend;  // sticky pending bits, meaningful on edge channels only

  for (genvar i = 0; i < NUM_INT; i++) begin : g_sync
    sync_chain_reg #(
      .SYNC_DEPTH(SYNC_DEPTH)
    ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (in_sync[i]),
      .q    (s[i])
    );
  end

`ifdef INT_SYNC_FILTER_EN
  localparam int               CNT_W    = filter_cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // f follows s only once s has disagreed with it for FILTER_LEN consecutive cycles.
  for (genvar i = 0; i < NUM_INT; i++) begin : g_filter
    logic [CNT_W-1:0] cnt;
    logic             f_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        f_q <= 1'b0;
      end else if (s[i] != f_q) begin
        if (cnt == CNT_LAST) begin
          f_q <= s[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign f[i] = f_q;
  end
`else
  assign f = s;
`endif

  // Set has priority over clear so a rise coinciding with a clear is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h    <= '0;
      pend <= '0;
    end else begin
      h    <= f;
      pend <= (f & ~h) | (pend & ~clear);
    end
  end

  for (genvar i = 0; i < NUM_INT; i++) begin : g_out
    if (chan_mode(EDGE_MASK[i]) == INT_EDGE) begin : g_edge
      assign out[i] = pend[i];
    end else begin : g_level
      assign out[i] = f[i];
    end
  end

  assign any = |out;

endmodule

// File: tb/tb_int_sync_crossing_sink_multi.sv
// Bench for int_sync_crossing_sink_multi: three instances (depth 3, 2, 5; channel 0 edge-mode)
// checked every cycle against an input-history reference model; honours INT_SYNC_FILTER_EN.
module tb_int_sync_crossing_sink_multi;

  localparam int               NI = 4;
  localparam int               FL = 2;
  localparam logic [NI-1:0]    EM = 4'b0001;
  localparam int               NDUT = 3;

  logic          clock;
  logic          reset;
  logic [NI-1:0] in_sync;
  logic [NI-1:0] clear;
  logic [NI-1:0] out_d3, out_d2, out_d5;
  logic          any_d3, any_d2, any_d5;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int_sync_crossing_sink_multi #(.NUM_INT(NI), .SYNC_DEPTH(3), .EDGE_MASK(EM), .FILTER_LEN(FL)) dut_d3 (
    .clock(clock), .reset(reset), .in_sync(in_sync), .clear(clear), .out(out_d3), .any(any_d3));
  int_sync_crossing_sink_multi #(.NUM_INT(NI), .SYNC_DEPTH(2), .EDGE_MASK(EM), .FILTER_LEN(FL)) dut_d2 (
    .clock(clock), .reset(reset), .in_sync(in_sync), .clear(clear), .out(out_d2), .any(any_d2));
  int_sync_crossing_sink_multi #(.NUM_INT(NI), .SYNC_DEPTH(5), .EDGE_MASK(EM), .FILTER_LEN(FL)) dut_d5 (
    .clock(clock), .reset(reset), .in_sync(in_sync), .clear(clear), .out(out_d5), .any(any_d5));

  logic [NI-1:0] obs_out [NDUT];
  logic          obs_any [NDUT];
  assign obs_out[0] = out_d3;
  assign obs_out[1] = out_d2;
  assign obs_out[2] = out_d5;
  assign obs_any[0] = any_d3;
  assign obs_any[1] = any_d2;
  assign obs_any[2] = any_d5;

  // Reference model: history of sampled inputs since reset release; synchronized value after
  // edge n is the input sampled at edge n-depth+1.
  logic [NI-1:0] hist [$];
  logic [NI-1:0] m_fcur [NDUT];
  logic [NI-1:0] m_fold [NDUT];
  logic [NI-1:0] m_pend [NDUT];
  logic [NI-1:0] m_out  [NDUT];
  int            m_run  [NDUT][NI];

  function automatic int depth_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic logic [NI-1:0] s_at(input int d, input int n);
    if (n - d < 0) return '0;
    return hist[n-d];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < NDUT; k++) begin
      m_fcur[k] = '0;
      m_fold[k] = '0;
      m_pend[k] = '0;
      m_out[k]  = '0;
      for (int c = 0; c < NI; c++) m_run[k][c] = 0;
    end
  endtask

  task automatic model_edge(input logic [NI-1:0] a, input logic [NI-1:0] c);
    int            n;
    int            d;
    logic [NI-1:0] pend_new;
    logic [NI-1:0] f_new;
    hist.push_back(a);
    n = hist.size();
    for (int k = 0; k < NDUT; k++) begin
      d = depth_of(k);
      pend_new = (m_fcur[k] & ~m_fold[k]) | (m_pend[k] & ~c);
`ifdef INT_SYNC_FILTER_EN
      begin
        logic [NI-1:0] s_pre;
        s_pre = s_at(d, n - 1);
        f_new = m_fcur[k];
        for (int ch = 0; ch < NI; ch++) begin
          if (s_pre[ch] != m_fcur[k][ch]) begin
            m_run[k][ch]++;
            if (m_run[k][ch] >= FL) begin
              f_new[ch]    = s_pre[ch];
              m_run[k][ch] = 0;
            end
          end else begin
            m_run[k][ch] = 0;
          end
        end
      end
`else
      f_new = s_at(d, n);
`endif
      m_fold[k] = m_fcur[k];
      m_fcur[k] = f_new;
      m_pend[k] = pend_new;
      m_out[k]  = (EM & pend_new) | (~EM & f_new);
    end
  endtask

  // scoreboard checks
  task automatic check_all(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      assert (obs_out[k] === m_out[k]) else begin
        failures++;
        $error("FAIL %s depth%0d out: observed=%b expected=%b", tag, depth_of(k), obs_out[k], m_out[k]);
      end
      checks++;
      assert (obs_any[k] === (|m_out[k])) else begin
        failures++;
        $error("FAIL %s depth%0d any: observed=%b expected=%b", tag, depth_of(k), obs_any[k], |m_out[k]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [NI-1:0] obs, input logic [NI-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input logic [NI-1:0] a, input logic [NI-1:0] c, input string tag);
    in_sync = a;
    clear   = c;
    @(posedge clock);
    model_edge(a, c);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input int num, input logic [NI-1:0] a, input string tag);
    repeat (num) tick(a, '0, tag);
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_assert");
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    in_sync = '0;
    clear   = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("in_reset");
    #3;
    reset = 1'b0;
    tick('0, '0, "first_after_release");
    ticks(2, '0, "idle");

    // level path on channel 2
    ticks(2, 4'b0100, "level_rise");
`ifndef INT_SYNC_FILTER_EN
    check_val("level_not_yet", out_d3, 4'b0000);
`endif
    tick(4'b0100, '0, "level_rise");
`ifndef INT_SYNC_FILTER_EN
    check_val("level_lat3", out_d3, 4'b0100);
`endif
    ticks(2, 4'b0100, "level_hold");
    ticks(2, 4'b0000, "level_fall");
    tick(4'b0000, '0, "level_fall");
`ifndef INT_SYNC_FILTER_EN
    check_val("level_fall_lat3", out_d3, 4'b0000);
`endif

    // edge path on channel 0
    ticks(3, 4'b0001, "edge_rise");
    tick(4'b0001, '0, "edge_rise");
`ifndef INT_SYNC_FILTER_EN
    check_val("edge_lat4", out_d3, 4'b0001);
`endif
    tick(4'b0001, '0, "edge_hold");
    ticks(3, 4'b0000, "edge_fall");
`ifndef INT_SYNC_FILTER_EN
    check_val("edge_sticky", out_d3, 4'b0001);
`endif
    tick(4'b0000, 4'b0001, "edge_clear");
    ticks(6, 4'b0000, "drain");

    // set/clear collision
    ticks(3, 4'b0001, "coll_rise");
    tick(4'b0001, 4'b0001, "coll_same_cycle");
`ifndef INT_SYNC_FILTER_EN
    check_val("coll_set_wins", out_d3, 4'b0001);
`endif
    ticks(2, 4'b0001, "coll_hold");
    tick(4'b0001, 4'b0001, "coll_late_clear");
`ifndef INT_SYNC_FILTER_EN
    check_val("coll_clear_alone", out_d3, 4'b0000);
`endif
    tick(4'b0001, 4'b0001, "clear_idle");

    // reset mid-operation with input held high across release
    ticks(5, 4'b0000, "pre_reset_low");
    ticks(4, 4'b0001, "pre_reset_pend");
    tick(4'b0011, '0, "pre_reset_l1");
    tick(4'b0001, '0, "pre_reset_l1");
    async_reset();
    ticks(3, 4'b0001, "post_reset");
`ifndef INT_SYNC_FILTER_EN
    check_val("post_reset_not_yet", out_d3, 4'b0000);
`endif
    tick(4'b0001, '0, "post_reset");
`ifndef INT_SYNC_FILTER_EN
    check_val("post_reset_lat4", out_d3, 4'b0001);
`endif

    // short and long pulses on a level channel
    ticks(8, 4'b0000, "pulse_idle");
    tick(4'b0100, '0, "pulse1");
    ticks(8, 4'b0000, "pulse1_after");
    ticks(4, 4'b0100, "pulse4");
    ticks(8, 4'b0000, "pulse4_after");

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [NI-1:0] a;
      logic [NI-1:0] c;
      a = NI'($urandom_range(0, 15));
      c = ($urandom_range(0, 3) == 0) ? NI'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 79) == 0) async_reset();
      tick(a, c, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_sync_crossing_sink_multi.md
Name: int_sync_crossing_sink_multi

Overview:
- Multi-channel, parametrised successor to the single-bit interrupt crossing sink.
- Resynchronises NUM_INT asynchronous interrupt lines into the local clock domain through an async-reset synchronizer of configurable depth.
- Each channel is either level-passthrough or rising-edge-captured into a sticky pending bit with a software clear.
- Sits at the receive side of interrupt crossings in front of the local interrupt controller.

Parameters:
- NUM_INT, 4, number of interrupt channels (>=1).
- SYNC_DEPTH, 3, synchronizer flops per channel (>=2; elaboration error otherwise).
- EDGE_MASK, '0 (NUM_INT bits), bit i=1 selects edge-capture mode for channel i; 0 selects level mode.
- FILTER_LEN, 2, stable-cycle count for the glitch filter; used only under the optional feature (>=1).

Ports:
- clock  input  1  sink-domain clock.
- reset  input  1  asynchronous, active-high reset.
- in_sync  input  NUM_INT  asynchronous interrupt lines from the source domain.
- clear  input  NUM_INT  per-channel pending clear, one-cycle pulse; ignored for level channels.
- out  output  NUM_INT  per-channel interrupt to the local controller.
- any  output  1  OR-reduction of out.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears synchronizer flops, edge-history flops, filter state and pending bits to 0. Out and any are 0 during reset and on the first cycle after release.
- Synchronizer: per channel, a SYNC_DEPTH-long shift chain of async-reset flops. s_i is the last stage. No combinational path from in_sync to any output.
- Level channel: out[i] = s_i (filtered if the feature is enabled).
  - Latency: a stable in_sync change is visible on out after exactly SYNC_DEPTH rising clock edges.
- Edge channel:
  - h_i is a history flop of s_i.
  - Rise event = s_i & ~h_i.
  - pend_i sets on a rise event and clears on clear[i]. If a rise and clear coincide, set wins (no lost interrupt).
  - out[i] = pend_i. Latency is SYNC_DEPTH+1 edges from the input rise.
  - A falling input does not affect pend_i.
  - Input held high across reset release counts as a rise and sets pend_i.
  - Repeated rises while pending are absorbed; there is no count.
- Reset mid-operation: pending state and in-flight synchronizer contents are discarded immediately (asynchronously). No output glitch high on reset assertion.
- clear on an already-clear pending bit has no effect.
- any is combinational from registered out; same latency as out.

Optional Feature:
- Macro: INT_SYNC_FILTER_EN.
- Defined:
  - Per-channel filter after the synchronizer. The filtered value f_i updates to s_i only after s_i has differed from f_i for FILTER_LEN consecutive cycles.
  - The counter resets when s_i returns to f_i. Counter width is clog2(FILTER_LEN+1).
  - Level and edge logic consume f_i in place of s_i. Latency increases by FILTER_LEN edges.
  - Pulses shorter than FILTER_LEN synchronized cycles are suppressed.
- Undefined: no filter logic and no counters; f_i = s_i. FILTER_LEN is ignored.

Decomposition:
- Package int_sync_pkg:
  - Constants INT_SYNC_DEFAULT_DEPTH=3 and INT_SYNC_MIN_DEPTH=2.
  - Typedef int_mode_e {INT_LEVEL, INT_EDGE}.
  - Function for counter width.
- Sub-module sync_chain_reg: single-bit, SYNC_DEPTH-parametrised async-reset shift chain, instantiated NUM_INT times in a generate loop.

Test Plan:
- Level path: NUM_INT=4, SYNC_DEPTH=3, EDGE_MASK=0. Raise in_sync[2] -> out=4'b0100 exactly 3 edges later and any=1. Drop it -> out=0 after 3 edges.
- Edge path: EDGE_MASK=4'b0001. Pulse in_sync[0] high for 5 cycles -> out[0]=1 at edge 4 and stays 1 after the input falls. Pulse clear[0] -> out[0]=0 next cycle.
- Set/clear collision: edge channel 0 with clear[0] asserted in the same cycle as the rise event -> out[0] remains 1. A later clear alone -> 0.
- Reset mid-operation: set pend on channel 0, toggle level channel 1 mid-chain, assert reset asynchronously between edges -> out=0 immediately. Release with in_sync[0]=1 held -> out[0]=1 after 4 edges.
- Depth sweep: SYNC_DEPTH=2 and 5 -> level latency is 2 and 5 edges; edge latency is 3 and 6.
- Filter (INT_SYNC_FILTER_EN, FILTER_LEN=2):
  - A 1-cycle pulse on level channel -> out never rises.
  - A 4-cycle pulse -> out rises at edge SYNC_DEPTH+2.
  - Without the macro, the same 1-cycle pulse reaches out.
